// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid port, decode-side
// valid/ready port and the redirect input from execute.
interface fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
           redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
           redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM and a small
// instruction buffer toward decode, with redirect flush and in-flight drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  fetch_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] RESET_PC_C = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      req_pc_q;
  logic             drop_q;
  logic [63:0]      buf_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic             inflight_after_redirect;
  logic [31:0]      redirect_pc;

  assign redirect_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign push        = (state_q == WAIT) && bus.imem_rvalid_i && !drop_q;
  assign pop         = (count_q != '0) && bus.instr_ready_i;
  assign count_nxt   = count_q + CNT_W'(push) - CNT_W'(pop);
  // A new request needs a free slot counting the word that lands this cycle.
  assign slot_free   = count_nxt < DEPTH_C;
  // A response still owed after this cycle must be dropped when it arrives;
  // an rvalid in the redirect cycle itself completes the old request.
  assign inflight_after_redirect = ((state_q == WAIT) && !bus.imem_rvalid_i) ||
                                   ((state_q == REQ) && bus.imem_gnt_i);

  assign bus.imem_req_o    = (state_q == REQ);
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = (count_q != '0);
  assign bus.instr_o       = buf_q[rd_ptr_q][63:32];
  assign bus.pc_o          = buf_q[rd_ptr_q][31:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC_C;
      req_pc_q <= RESET_PC_C;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) buf_q[i] <= '0;
    end else if (bus.redirect_i) begin
      pc_q     <= redirect_pc;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      if (inflight_after_redirect) begin
        state_q <= WAIT;
        drop_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
        drop_q  <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= {bus.imem_rdata_i, req_pc_q};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_nxt;
      case (state_q)
        IDLE: if (slot_free) state_q <= REQ;
        REQ: begin
          if (bus.imem_gnt_i) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid_i) begin
            drop_q  <= 1'b0;
            state_q <= slot_free ? REQ : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table for start-up and redirect
// cases, then a modelled memory/decode environment for stalls, reset and wrap.
module tb_fetch_unit;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  fetch_if bus();
  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );

  logic        m_gnt, m_rvalid, r_gnt, r_rvalid, ready, redirect, resp_en, mon_en;
  logic [31:0] m_rdata, r_rdata, rpc;
  assign bus.imem_gnt_i    = resp_en ? r_gnt : m_gnt;
  assign bus.imem_rvalid_i = resp_en ? r_rvalid : m_rvalid;
  assign bus.imem_rdata_i  = resp_en ? r_rdata : m_rdata;
  assign bus.instr_ready_i = ready;
  assign bus.redirect_i    = redirect;
  assign bus.redirect_pc_i = rpc;

  int n_tests = 0;
  int n_fail  = 0;

  // memory responder / output monitor state
  logic        pend, prev_req, prev_gnt, prev_redir;
  logic [31:0] pend_addr, prev_addr, exp_pc;
  int          pend_cnt, gnt_pct, lat_max, mon_cnt, base;

  typedef struct {
    logic g; logic rv; logic [31:0] rd; logic rdy; logic re; logic [31:0] rp;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic ck;
    logic [31:0] e_pc; logic [31:0] e_instr;
  } vec_t;
  vec_t tbl[23];

  function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic re, logic [31:0] rp,
                              logic er, logic [31:0] ea, logic ev, logic ck,
                              logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.g = g; v.rv = rv; v.rd = rd; v.rdy = 1'b1; v.re = re; v.rp = rp;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.ck = ck; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: monitor + responder act at negedge, control returns at posedge+1.
  task automatic cycle();
    @(negedge clk_i);
    if (mon_en && bus.instr_valid_o && ready) begin
      check($sformatf("mon_pc%0d", mon_cnt), bus.pc_o, exp_pc);
      check($sformatf("mon_instr%0d", mon_cnt), bus.instr_o, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      mon_cnt++;
    end
    if (resp_en) begin
      if (prev_req && !prev_gnt && !prev_redir && bus.imem_req_o)
        check("addr_stable", bus.imem_addr_o, prev_addr);
      prev_req = bus.imem_req_o; prev_addr = bus.imem_addr_o; prev_redir = redirect;
      r_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          r_rvalid = 1'b1; r_rdata = word_of(pend_addr); pend = 1'b0;
        end else pend_cnt--;
      end
      r_gnt = 1'b0;
      if (bus.imem_req_o && !pend && int'($urandom_range(99)) < gnt_pct) begin
        r_gnt = 1'b1; pend = 1'b1; pend_addr = bus.imem_addr_o;
        pend_cnt = int'($urandom_range(lat_max - 1));
      end
      prev_gnt = r_gnt;
    end else begin
      r_gnt = 1'b0; r_rvalid = 1'b0; pend = 1'b0; prev_req = 1'b0;
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_gnt = 0; m_rvalid = 0; m_rdata = 0; r_gnt = 0; r_rvalid = 0; r_rdata = 0;
    ready = 1; redirect = 0; rpc = 0; resp_en = 0; mon_en = 0;
    pend = 0; prev_req = 0; prev_gnt = 0; prev_redir = 0; pend_addr = 0; prev_addr = 0;
    exp_pc = 0; pend_cnt = 0; gnt_pct = 100; lat_max = 1; mon_cnt = 0; base = 0;

    //            g  rv rdata          re rpc            req addr          v  ck pc             instr
    tbl[0]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0100, 0, 1, 32'h0,         32'h0);
    tbl[1]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0100, 0, 0, 32'h0,         32'h0);
    tbl[2]  = mk(0, 1, 32'hA000_0000, 0, 32'h0,         0, 32'h0000_0104, 0, 0, 32'h0,         32'h0);
    tbl[3]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0104, 1, 1, 32'h0000_0100, 32'hA000_0000);
    tbl[4]  = mk(0, 1, 32'hA000_0001, 0, 32'h0,         0, 32'h0000_0108, 0, 0, 32'h0,         32'h0);
    tbl[5]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0108, 1, 1, 32'h0000_0104, 32'hA000_0001);
    tbl[6]  = mk(0, 1, 32'hA000_0002, 0, 32'h0,         0, 32'h0000_010C, 0, 0, 32'h0,         32'h0);
    tbl[7]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_010C, 1, 1, 32'h0000_0108, 32'hA000_0002);
    tbl[8]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_010C, 0, 0, 32'h0,         32'h0);
    tbl[9]  = mk(0, 0, 32'h0,         1, 32'h0000_2002, 0, 32'h0000_0110, 0, 0, 32'h0,         32'h0);
    tbl[10] = mk(0, 1, 32'hDEAD_DEAD, 0, 32'h0,         0, 32'h0000_2000, 0, 0, 32'h0,         32'h0);
    tbl[11] = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_2000, 0, 0, 32'h0,         32'h0);
    tbl[12] = mk(0, 1, 32'hB000_0000, 0, 32'h0,         0, 32'h0000_2004, 0, 0, 32'h0,         32'h0);
    tbl[13] = mk(1, 0, 32'h0,         1, 32'h0000_3000, 1, 32'h0000_2004, 1, 1, 32'h0000_2000, 32'hB000_0000);
    tbl[14] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3000, 0, 0, 32'h0,         32'h0);
    tbl[15] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3000, 0, 0, 32'h0,         32'h0);
    tbl[16] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3000, 0, 0, 32'h0,         32'h0);
    tbl[17] = mk(0, 1, 32'hBAD0_0001, 0, 32'h0,         0, 32'h0000_3000, 0, 0, 32'h0,         32'h0);
    tbl[18] = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3000, 0, 0, 32'h0,         32'h0);
    tbl[19] = mk(0, 1, 32'hC000_0000, 0, 32'h0,         0, 32'h0000_3004, 0, 0, 32'h0,         32'h0);
    tbl[20] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3004, 1, 1, 32'h0000_3000, 32'hC000_0000);
    tbl[21] = mk(0, 1, 32'hBAD0_0002, 0, 32'h0,         1, 32'h0000_3004, 0, 0, 32'h0,         32'h0);
    tbl[22] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3004, 0, 0, 32'h0,         32'h0);

    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // start-up stream, redirect in WAIT, redirect with REQ+gnt, late/ignored rvalid
    for (int i = 0; i < 23; i++) begin
      @(negedge clk_i);
      check($sformatf("row%0d_req", i), 32'(bus.imem_req_o), 32'(tbl[i].e_req));
      check($sformatf("row%0d_addr", i), bus.imem_addr_o, tbl[i].e_addr);
      check($sformatf("row%0d_valid", i), 32'(bus.instr_valid_o), 32'(tbl[i].e_valid));
      if (tbl[i].ck) begin
        check($sformatf("row%0d_pc", i), bus.pc_o, tbl[i].e_pc);
        check($sformatf("row%0d_instr", i), bus.instr_o, tbl[i].e_instr);
      end
      m_gnt = tbl[i].g; m_rvalid = tbl[i].rv; m_rdata = tbl[i].rd;
      ready = tbl[i].rdy; redirect = tbl[i].re; rpc = tbl[i].rp;
    end
    @(posedge clk_i); #1;

    // backpressure: buffer fills to depth, request stops, head holds
    m_gnt = 0; m_rvalid = 0; ready = 0; redirect = 1; rpc = 32'h0000_4000;
    cycle();
    redirect = 0; exp_pc = 32'h0000_4000; resp_en = 1; mon_en = 1; gnt_pct = 100; lat_max = 1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (bus.instr_valid_o) check("t2_head_pc", bus.pc_o, 32'h0000_4000);
    end
    check("t2_req_low", 32'(bus.imem_req_o), 32'd0);
    check("t2_valid", 32'(bus.instr_valid_o), 32'd1);
    check("t2_instr", bus.instr_o, word_of(32'h0000_4000));
    ready = 1;
    cycle();
    check("t2_second", 32'(bus.instr_valid_o), 32'd1);
    cycle();
    check("t2_only_two", 32'(bus.instr_valid_o), 32'd0);
    for (int k = 0; k < 40 && mon_cnt < 4; k++) cycle();
    check("t2_drained", 32'(mon_cnt >= 4), 32'd1);

    // random grant stalls, latency 1..8, random decode stalls
    gnt_pct = 60; lat_max = 8; base = mon_cnt;
    for (int k = 0; k < 500; k++) begin
      ready = ($urandom_range(9) < 7);
      cycle();
    end
    check("t5_progress", 32'(mon_cnt - base >= 20), 32'd1);

    // reset during WAIT with a late response
    resp_en = 0; mon_en = 0; ready = 1; rst_i = 1;
    cycle(); cycle();
    rst_i = 0;
    cycle();
    check("t6_req", 32'(bus.imem_req_o), 32'd1);
    check("t6_addr", bus.imem_addr_o, 32'h0000_0100);
    m_gnt = 1;
    cycle();
    m_gnt = 0;
    check("t6_wait", 32'(bus.imem_req_o), 32'd0);
    rst_i = 1;
    cycle();
    rst_i = 0;
    check("t6_rst_valid", 32'(bus.instr_valid_o), 32'd0);
    check("t6_rst_addr", bus.imem_addr_o, 32'h0000_0100);
    cycle();
    m_rvalid = 1; m_rdata = 32'hBAD0_0003;
    cycle();
    m_rvalid = 0;
    check("t6_late_ignored", 32'(bus.instr_valid_o), 32'd0);
    check("t6_req_again", 32'(bus.imem_req_o), 32'd1);
    m_gnt = 1;
    cycle();
    m_gnt = 0; m_rvalid = 1; m_rdata = word_of(32'h0000_0100);
    cycle();
    m_rvalid = 0;
    check("t6_first_valid", 32'(bus.instr_valid_o), 32'd1);
    check("t6_first_pc", bus.pc_o, 32'h0000_0100);
    check("t6_first_instr", bus.instr_o, word_of(32'h0000_0100));

    // PC wrap from 0xFFFF_FFF8
    redirect = 1; rpc = 32'hFFFF_FFF8;
    cycle();
    redirect = 0;
    check("wrap_flush", 32'(bus.instr_valid_o), 32'd0);
    check("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFF8);
    exp_pc = 32'hFFFF_FFF8; base = mon_cnt; mon_en = 1; resp_en = 1; gnt_pct = 100; lat_max = 1;
    for (int k = 0; k < 40 && mon_cnt < base + 3; k++) cycle();
    check("wrap_words", 32'(mon_cnt >= base + 3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
